// File: rtl/branch_direction_predictor_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
// Counter encodings and the saturating update live here for reuse.
package bp_pkg;

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic        actual_taken;
  } bp_update_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RST = CTR_WNT;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  function automatic logic [1:0] ctr_sat_update(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_direction_predictor_pht.sv
// Pattern-history table: 2-bit counters with a forwarding read port,
// one read-modify-write port and the init-sweep write port.
module bp_pht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             i_init_en,
  input  logic [IDX_W-1:0] i_init_idx,
  input  logic             i_rmw_en,
  input  logic [IDX_W-1:0] i_rmw_idx,
  input  logic             i_rmw_taken,
  output logic             o_rmw_old_msb,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr
);

  logic [1:0] r_mem [ENTRIES];
  logic [1:0] w_rmw_old;
  logic [1:0] w_rmw_new;
  logic       w_fwd;

  assign w_rmw_old     = r_mem[i_rmw_idx];
  assign w_rmw_new     = ctr_sat_update(w_rmw_old, i_rmw_taken);
  assign o_rmw_old_msb = w_rmw_old[1];

  // The query sees the value being committed this cycle.
  assign w_fwd    = i_rmw_en && (i_rmw_idx == i_rd_idx);
  assign o_rd_ctr = w_fwd ? w_rmw_new : r_mem[i_rd_idx];

  always_ff @(posedge clk) begin
    if (i_init_en) begin
      r_mem[i_init_idx] <= CTR_RST;
    end else if (i_rmw_en) begin
      r_mem[i_rmw_idx] <= w_rmw_new;
    end
  end

endmodule

// File: rtl/branch_direction_predictor.sv
// Gshare direction predictor trained by resolved-branch pulses; holds
// the init FSM, update stage S1, resolved history and perf counters.
module branch_direction_predictor
  import bp_pkg::*;
#(
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] query_pc,
  output logic        query_taken,
  output logic        ready,
  input  bp_update_t  bp_update,
  output logic [((GHR_WIDTH < 1) ? 1 : GHR_WIDTH)-1:0] ghr,
  output logic [31:0] update_count,
  output logic [31:0] mispredict_count,
  output logic [31:0] drop_count
);

  localparam int IDX_W = $clog2(PHT_ENTRIES);
  localparam int GW    = (GHR_WIDTH < 1) ? 1 : GHR_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHT_ENTRIES - 1);

  bp_state_e        r_state;
  bp_state_e        w_state_nxt;
  logic [IDX_W-1:0] r_sweep;
  logic             w_init_en;

  logic [GW-1:0]    r_ghr;
  logic [GW-1:0]    w_ghr_nxt;

  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_s1_taken;

  logic [31:0]      r_upd_cnt;
  logic [31:0]      r_mis_cnt;
  logic [31:0]      r_drop_cnt;

  logic             w_upd_acc;
  logic             w_upd_drop;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_q_idx;
  logic [1:0]       w_q_ctr;
  logic             w_old_msb;
  logic             w_mispred;
  logic             w_unused;

  function automatic logic [IDX_W-1:0] f_idx(
    input logic [31:0]   pc,
    input logic [GW-1:0] h
  );
    return pc[IDX_W+1:2] ^ IDX_W'(h);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_init_en   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_en = 1'b1;
        if (r_sweep == LAST_IDX) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_upd_acc  = bp_update.en && (r_state == ST_RUN);
  assign w_upd_drop = bp_update.en && (r_state == ST_INIT);
  assign w_upd_idx  = f_idx(bp_update.pc, r_ghr);
  assign w_q_idx    = f_idx(query_pc, r_ghr);

  // Truncating the concatenation drops the oldest history bit.
  assign w_ghr_nxt = (GHR_WIDTH == 0) ? '0 :
                     GW'({r_ghr, bp_update.actual_taken});

  assign w_mispred = w_old_msb != r_s1_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_sweep    <= '0;
      r_ghr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_taken <= 1'b0;
      r_upd_cnt  <= '0;
      r_mis_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      if (w_init_en) r_sweep <= r_sweep + IDX_W'(1);
      r_s1_valid <= w_upd_acc;
      if (w_upd_acc) begin
        r_s1_idx   <= w_upd_idx;
        r_s1_taken <= bp_update.actual_taken;
        r_ghr      <= w_ghr_nxt;
      end
      if (r_s1_valid) begin
        r_upd_cnt <= r_upd_cnt + 32'd1;
        if (w_mispred) r_mis_cnt <= r_mis_cnt + 32'd1;
      end
      if (w_upd_drop) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  bp_pht #(
    .ENTRIES (PHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_pht (
    .clk           (clk),
    .i_init_en     (w_init_en && !rst),
    .i_init_idx    (r_sweep),
    .i_rmw_en      (r_s1_valid),
    .i_rmw_idx     (r_s1_idx),
    .i_rmw_taken   (r_s1_taken),
    .o_rmw_old_msb (w_old_msb),
    .i_rd_idx      (w_q_idx),
    .o_rd_ctr      (w_q_ctr)
  );

  assign ready            = (r_state == ST_RUN);
  assign query_taken      = ready & w_q_ctr[1];
  assign ghr              = r_ghr;
  assign update_count     = r_upd_cnt;
  assign mispredict_count = r_mis_cnt;
  assign drop_count       = r_drop_cnt;

  assign w_unused = ^{query_pc[31:IDX_W+2], query_pc[1:0],
                      bp_update.pc[31:IDX_W+2], bp_update.pc[1:0]};

endmodule
